// File: rtl/i2c_sda_tx_driver_if.sv
// Bus between the slave controller FSM and the SDA TX driver.
// sda_oe exists only when I2C_SDA_OE_EN is defined.
interface i2c_sda_tx_driver_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]            sda_mode;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_push;
  logic                  load;
  logic                  shift_strobe;
  logic                  sda_out;
  logic                  tx_full;
  logic                  tx_empty;
  logic [CntW-1:0]       tx_count;
  logic                  byte_done;
  logic                  underflow;
  logic                  overflow;
`ifdef I2C_SDA_OE_EN
  logic                  sda_oe;
`endif

  modport master (
    output sda_mode, tx_data, tx_push, load, shift_strobe,
`ifdef I2C_SDA_OE_EN
    input  sda_oe,
`endif
    input  sda_out, tx_full, tx_empty, tx_count, byte_done, underflow, overflow
  );

  modport slave (
    input  sda_mode, tx_data, tx_push, load, shift_strobe,
`ifdef I2C_SDA_OE_EN
    output sda_oe,
`endif
    output sda_out, tx_full, tx_empty, tx_count, byte_done, underflow, overflow
  );
endinterface

// File: rtl/i2c_sda_tx_driver.sv
// I2C slave SDA transmit driver: TX FIFO, MSB-first shift register, registered SDA.
// Define I2C_SDA_OE_EN to add the registered open-drain enable sda_oe.
module i2c_sda_tx_driver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  i2c_sda_tx_driver_if.slave bus
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
  localparam logic [1:0]      ModeAck = 2'd1;
  localparam logic [1:0]      ModeTx  = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  full_q, empty_q;
  logic                  byte_done_q, byte_done_d;
  logic                  underflow_q, underflow_d;
  logic                  overflow_q, overflow_d;
  logic                  sda_out_q, sda_out_d;
  logic                  is_empty, is_full, pop, wr_en;

  // FIFO bookkeeping; a push into a full FIFO is accepted when a pop frees the slot.
  always_comb begin
    is_empty    = (count_q == '0);
    is_full     = (count_q == FullCnt);
    pop         = bus.load & ~is_empty;
    wr_en       = bus.tx_push & (~is_full | pop);
    underflow_d = bus.load & is_empty;
    overflow_d  = bus.tx_push & ~wr_en;
    rd_ptr_d    = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d     = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Shift register and bit counter; load has priority over the strobe.
  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = 1'b0;
    if (bus.load) begin
      shreg_d   = is_empty ? '1 : mem_q[rd_ptr_q];
      bit_cnt_d = '0;
    end else if (bus.shift_strobe && (bus.sda_mode == ModeTx)) begin
      shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b1};
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d   = '0;
        byte_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    unique case (bus.sda_mode)
      ModeTx:  sda_out_d = shreg_d[DATA_WIDTH-1];
      ModeAck: sda_out_d = 1'b0;
      default: sda_out_d = 1'b1;
    endcase
  end

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      shreg_q     <= '1;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      sda_out_q   <= 1'b1;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == FullCnt);
      empty_q     <= (count_d == '0);
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      sda_out_q   <= sda_out_d;
    end
  end

`ifdef I2C_SDA_OE_EN
  logic sda_oe_q;

  always_ff @(posedge clk) begin
    if (rst) sda_oe_q <= 1'b0;
    else     sda_oe_q <= ~sda_out_d;
  end

  assign bus.sda_oe = sda_oe_q;
`endif

  assign bus.sda_out   = sda_out_q;
  assign bus.tx_full   = full_q;
  assign bus.tx_empty  = empty_q;
  assign bus.tx_count  = count_q;
  assign bus.byte_done = byte_done_q;
  assign bus.underflow = underflow_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_i2c_sda_tx_driver.sv
// Directed self-checking bench for i2c_sda_tx_driver (DATA_WIDTH=8, FIFO_DEPTH=4).
module tb_i2c_sda_tx_driver;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  i2c_sda_tx_driver_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus ();

  i2c_sda_tx_driver #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_sda(input string tag, input logic exp);
    chk(tag, 32'(bus.sda_out), 32'(exp));
`ifdef I2C_SDA_OE_EN
    chk({tag, "_oe"}, 32'(bus.sda_oe), 32'(~exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.tx_push = 1'b1;
    bus.tx_data = d;
    tick();
    bus.tx_push = 1'b0;
  endtask

  task automatic strobe();
    bus.shift_strobe = 1'b1;
    tick();
    bus.shift_strobe = 1'b0;
  endtask

  // Load a word (optionally pushing another in the same cycle) and shift it out in mode 3.
  task automatic send_byte(input logic [7:0] w, input bit push_too, input logic [7:0] pd);
    bus.load = 1'b1;
    if (push_too) begin
      bus.tx_push = 1'b1;
      bus.tx_data = pd;
    end
    tick();
    bus.load    = 1'b0;
    bus.tx_push = 1'b0;
    chk_sda("ld_msb", w[7]);
    for (int i = 1; i <= 8; i++) begin
      strobe();
      if (i < 8) begin
        chk_sda("bit", w[7-i]);
        chk("bd_low", 32'(bus.byte_done), 32'd0);
      end else begin
        chk_sda("released", 1'b1);
        chk("bd_pulse", 32'(bus.byte_done), 32'd1);
      end
      tick();
      if (i == 8) chk("bd_one_cycle", 32'(bus.byte_done), 32'd0);
      tick(); tick(); tick();
      if (i < 8) chk_sda("bit_hold", w[7-i]);
    end
  endtask

  logic [1:0] modes [3];
  logic       mode_exp [3];

  initial begin
    modes    = '{2'd0, 2'd1, 2'd2};
    mode_exp = '{1'b1, 1'b0, 1'b1};
    bus.sda_mode     = 2'd0;
    bus.tx_data      = '0;
    bus.tx_push      = 1'b0;
    bus.load         = 1'b0;
    bus.shift_strobe = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_sda("rst_sda", 1'b1);
    chk("rst_count", 32'(bus.tx_count), 32'd0);
    chk("rst_empty", 32'(bus.tx_empty), 32'd1);
    chk("rst_full", 32'(bus.tx_full), 32'd0);
    chk("rst_flags", {29'd0, bus.byte_done, bus.underflow, bus.overflow}, 32'd0);

    // Idle, ACK, NACK levels with one-cycle latency
    for (int m = 0; m < 3; m++) begin
      bus.sda_mode = modes[m];
      if (m > 0) chk_sda("mode_latency", mode_exp[m-1]);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk_sda("mode_level", mode_exp[m]);
      end
      chk("mode_flags", {29'd0, bus.byte_done, bus.underflow, bus.overflow}, 32'd0);
    end

    // Single byte 0x55
    bus.sda_mode = 2'd3;
    tick();
    chk_sda("tx_idle_ones", 1'b1);
    push(8'h55);
    chk("one_count", 32'(bus.tx_count), 32'd1);
    chk("one_empty", 32'(bus.tx_empty), 32'd0);
    send_byte(8'h55, 1'b0, 8'h00);
    chk("drained_empty", 32'(bus.tx_empty), 32'd1);

    // Fill, overflow, then push+load while full
    push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
    chk("fill_count", 32'(bus.tx_count), 32'd4);
    chk("fill_full", 32'(bus.tx_full), 32'd1);
    chk("no_ovf_yet", 32'(bus.overflow), 32'd0);
    push(8'h11);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.tx_count), 32'd4);
    tick();
    chk("ovf_one_cycle", 32'(bus.overflow), 32'd0);
    bus.load = 1'b1;
    bus.tx_push = 1'b1;
    bus.tx_data = 8'h77;
    tick();
    bus.load = 1'b0;
    bus.tx_push = 1'b0;
    chk("full_pushload_count", 32'(bus.tx_count), 32'd4);
    chk("full_pushload_ovf", 32'(bus.overflow), 32'd0);
    chk_sda("a5_msb", 1'b1);
    for (int i = 1; i <= 8; i++) strobe();
    chk("a5_done", 32'(bus.byte_done), 32'd1);
    send_byte(8'h3C, 1'b0, 8'h00);
    send_byte(8'hFF, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h77, 1'b0, 8'h00);
    chk("fifo_order_empty", 32'(bus.tx_empty), 32'd1);

    // Underflow with simultaneous push
    bus.load = 1'b1;
    bus.tx_push = 1'b1;
    bus.tx_data = 8'h81;
    tick();
    bus.load = 1'b0;
    bus.tx_push = 1'b0;
    chk("udf_pulse", 32'(bus.underflow), 32'd1);
    chk("udf_count", 32'(bus.tx_count), 32'd1);
    chk_sda("udf_sda", 1'b1);
    for (int i = 1; i <= 8; i++) begin
      strobe();
      chk_sda("udf_ones", 1'b1);
    end
    chk("udf_bd", 32'(bus.byte_done), 32'd1);
    tick();
    chk("udf_one_cycle", 32'(bus.underflow), 32'd0);
    send_byte(8'h81, 1'b0, 8'h00);

    // Mid-byte ACK excursion on 0xC3 (1100_0011)
    push(8'hC3);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk_sda("c3_b7", 1'b1);
    strobe(); chk_sda("c3_b6", 1'b1);
    strobe(); chk_sda("c3_b5", 1'b0);
    strobe(); chk_sda("c3_b4", 1'b0);
    bus.sda_mode = 2'd1;
    tick(); chk_sda("ack0", 1'b0);
    strobe(); chk_sda("ack1", 1'b0);
    tick(); chk_sda("ack2", 1'b0);
    strobe(); chk_sda("ack3", 1'b0);
    chk("ack_no_bd", 32'(bus.byte_done), 32'd0);
    bus.sda_mode = 2'd3;
    tick(); chk_sda("resume_b4", 1'b0);
    strobe(); chk_sda("resume_b3", 1'b0);
    strobe(); chk_sda("resume_b2", 1'b0);
    strobe(); chk_sda("resume_b1", 1'b1);
    chk("resume_no_bd", 32'(bus.byte_done), 32'd0);
    strobe(); chk_sda("resume_b0", 1'b1);
    strobe();
    chk("resume_bd", 32'(bus.byte_done), 32'd1);
    chk_sda("resume_released", 1'b1);

    // Reset mid-byte discards the word and the FIFO
    push(8'h0F); push(8'hC3);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk_sda("pre_rst_msb", 1'b0);
    strobe();
    chk("pre_rst_count", 32'(bus.tx_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_sda("midrst_sda", 1'b1);
    chk("midrst_count", 32'(bus.tx_count), 32'd0);
    chk("midrst_empty", 32'(bus.tx_empty), 32'd1);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("post_rst_udf", 32'(bus.underflow), 32'd1);
    chk_sda("post_rst_sda", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
